uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with built-in baud divider and TX FIFO.

---
 rtl/uart_tx_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with an integrated baud divider and a transmit FIFO.
//   Producers push words at mclk rate. The block serialises the queued
//   words back-to-back, with no idle gap between frames. The frame format
//   (data bits, parity, stop bits) is fixed by parameters.
//
//   Ports
//     mclk         in   system clock
//     reset        in   synchronous, active-high reset
//     data         in   word to transmit (DATA_BITS wide)
//     data_strobe  in   push data this cycle
//     ready        out  FIFO not full; a push is accepted only while high
//     serial       out  TX line, idles high, registered
//     busy         out  frame in flight or FIFO non-empty
//     level        out  FIFO occupancy
//     overflow     out  sticky: a push arrived while ready was low
//
//   FSM states
//     state    | meaning
//     ---------+----------------------------------------------------------
//     S_IDLE   | line high; pops the head word as soon as the FIFO is non-empty
//     S_START  | start bit (low)
//     S_DATA   | data bits, LSB first
//     S_PARITY | parity bit (only reachable when PARITY != 0)
//     S_STOP   | stop bit(s); chains straight into S_START if a word is queued

module uart_tx_fifo #(
  parameter int CLK_DIV    = 48,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          data_strobe,
  output logic                          ready,
  output logic                          serial,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);
  localparam logic          STOP_EXTRA = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  // Odd parity is the inverted XOR of the data bits, so its accumulator
  // starts at 1.
  localparam logic          PAR_INIT = (PARITY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic [CW-1:0]          bcnt;
  logic [BW-1:0]          bit_cnt;
  logic                   stop_cnt;
  logic [DATA_BITS-1:0]   shifter;
  logic                   par;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   push;
  logic                   pop;
  logic [DATA_BITS-1:0]   head;

  assign ready = (level != LVL_FULL);
  assign push  = data_strobe && ready;
  assign head  = mem[rd_ptr];
  assign busy  = (state != S_IDLE) || (level != '0);

  // A word leaves the FIFO when the line is idle, or at the last cycle of
  // the final stop bit, so that the next start bit follows without a gap.
  assign pop = (level != '0) &&
               ((state == S_IDLE) ||
                ((state == S_STOP) && (bcnt == '0) && !stop_cnt));

  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !push) begin
        level <= level - LVL_ONE;
      end
      if (data_strobe && !ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // serial is registered with the value of the bit being entered, so the
  // line and the state always change on the same edge. The first START
  // after IDLE is loaded with one extra count: the pop edge leaves the line
  // high, and the start bit then lasts a full CLK_DIV cycles from the next
  // edge.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state    <= S_IDLE;
      serial   <= 1'b1;
      bcnt     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shifter  <= '0;
      par      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          serial <= 1'b1;
          if (pop) begin
            shifter <= head;
            par     <= PAR_INIT;
            bcnt    <= CW'(CLK_DIV);
            state   <= S_START;
          end
        end

        S_START: begin
          if (bcnt == '0) begin
            serial  <= shifter[0];
            par     <= par ^ shifter[0];
            shifter <= shifter >> 1;
            bit_cnt <= '0;
            bcnt    <= CNT_BIT;
            state   <= S_DATA;
          end else begin
            serial <= 1'b0;
            bcnt   <= bcnt - CNT_ONE;
          end
        end

        S_DATA: begin
          if (bcnt == '0) begin
            bcnt <= CNT_BIT;
            if (bit_cnt == IDX_LAST) begin
              if (PARITY != 0) begin
                serial <= par;
                state  <= S_PARITY;
              end else begin
                serial   <= 1'b1;
                stop_cnt <= STOP_EXTRA;
                state    <= S_STOP;
              end
            end else begin
              serial  <= shifter[0];
              par     <= par ^ shifter[0];
              shifter <= shifter >> 1;
              bit_cnt <= bit_cnt + IDX_ONE;
            end
          end else begin
            bcnt <= bcnt - CNT_ONE;
          end
        end

        S_PARITY: begin
          if (bcnt == '0) begin
            serial   <= 1'b1;
            stop_cnt <= STOP_EXTRA;
            bcnt     <= CNT_BIT;
            state    <= S_STOP;
          end else begin
            bcnt <= bcnt - CNT_ONE;
          end
        end

        S_STOP: begin
          if (bcnt == '0) begin
            if (stop_cnt) begin
              stop_cnt <= 1'b0;
              bcnt     <= CNT_BIT;
            end else if (pop) begin
              shifter <= head;
              par     <= PAR_INIT;
              serial  <= 1'b0;
              bcnt    <= CNT_BIT;
              state   <= S_START;
            end else begin
              serial <= 1'b1;
              state  <= S_IDLE;
            end
          end else begin
            bcnt <= bcnt - CNT_ONE;
          end
        end

        default: begin
          serial <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo.
// The bench uses three instances:
//   u0 - default format (CLK_DIV=48, 8N1, depth 16)
//   u1 - CLK_DIV=4, 7 data bits, even parity, 2 stop bits
//   u2 - CLK_DIV=4, 8N1, depth 4
// Every expected frame is written as a literal in which bit k is the line
// level during bit time k.

module tb_uart_tx_fifo;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic       rst0, rst1, rst2;
  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic       stb0, stb1, stb2;
  logic       rdy0, rdy1, rdy2;
  logic       ser0, ser1, ser2;
  logic       bsy0, bsy1, bsy2;
  logic [4:0] lvl0, lvl1;
  logic [2:0] lvl2;
  logic       ovf0, ovf1, ovf2;

  uart_tx_fifo u0 (
    .mclk(mclk), .reset(rst0), .data(d0), .data_strobe(stb0),
    .ready(rdy0), .serial(ser0), .busy(bsy0), .level(lvl0), .overflow(ovf0)
  );

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .mclk(mclk), .reset(rst1), .data(d1), .data_strobe(stb1),
    .ready(rdy1), .serial(ser1), .busy(bsy1), .level(lvl1), .overflow(ovf1)
  );

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4)) u2 (
    .mclk(mclk), .reset(rst2), .data(d2), .data_strobe(stb2),
    .ready(rdy2), .serial(ser2), .busy(bsy2), .level(lvl2), .overflow(ovf2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;

  logic       m_serial, m_busy, m_ready, m_overflow;
  logic [4:0] m_level;

  always_comb begin
    m_serial = ser0; m_busy = bsy0; m_ready = rdy0; m_overflow = ovf0; m_level = lvl0;
    case (sel)
      1: begin
        m_serial = ser1; m_busy = bsy1; m_ready = rdy1; m_overflow = ovf1; m_level = lvl1;
      end
      2: begin
        m_serial = ser2; m_busy = bsy2; m_ready = rdy2; m_overflow = ovf2; m_level = {2'b00, lvl2};
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pick(input int s);
    sel = s;
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Entered at a negedge that lies 'skip' cycles into bit 0. The task checks
  // the first and last cycle of every bit, so a bit that is one cycle too
  // long or too short is caught. It returns at the negedge after the edge
  // that ends the last bit given.
  task automatic check_frame(input string tag, input int div, input int nbits,
                             input logic [15:0] bits, input int skip);
    int first;
    for (int k = 0; k < nbits; k++) begin
      first = (k == 0) ? skip : 0;
      check($sformatf("%s bit%0d head", tag, k), m_serial, bits[k]);
      repeat (div - 1 - first) @(negedge mclk);
      check($sformatf("%s bit%0d tail", tag, k), m_serial, bits[k]);
      if (k == nbits - 1) check($sformatf("%s busy in frame", tag), m_busy, 1);
      @(negedge mclk);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    d0 = '0; d1 = '0; d2 = '0;
    stb0 = 1'b0; stb1 = 1'b0; stb2 = 1'b0;
    cycles(2);

    for (int s = 0; s < 3; s++) begin
      pick(s);
      check($sformatf("reset serial u%0d", s), m_serial, 1);
      check($sformatf("reset ready u%0d", s), m_ready, 1);
      check($sformatf("reset busy u%0d", s), m_busy, 0);
      check($sformatf("reset level u%0d", s), m_level, 0);
      check($sformatf("reset overflow u%0d", s), m_overflow, 0);
    end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    cycles(1);

    // 1: default format, 0x41. Serial falls two edges after the push.
    pick(0);
    d0 = 8'h41; stb0 = 1'b1;
    cycles(1);
    stb0 = 1'b0;
    check("t1 busy after push", m_busy, 1);
    check("t1 level after push", m_level, 1);
    check("t1 serial push+0", m_serial, 1);
    cycles(1);
    check("t1 serial push+1", m_serial, 1);
    cycles(1);
    check_frame("t1", 48, 10, 16'h0282, 0);
    check("t1 busy after frame", m_busy, 0);
    check("t1 idle line", m_serial, 1);

    // 2: 7 data bits, even parity, 2 stop bits: 0,1,1,0,0,0,0,0,0,1,1
    pick(1);
    d1 = 7'h03; stb1 = 1'b1;
    cycles(1);
    stb1 = 1'b0;
    cycles(2);
    check_frame("t2", 4, 11, 16'h0606, 0);
    check("t2 busy after frame", m_busy, 0);

    // 3: three pushes on consecutive cycles -> three frames without gaps
    pick(2);
    d2 = 8'h0D; stb2 = 1'b1;
    cycles(1);
    d2 = 8'h0A;
    cycles(1);
    d2 = 8'h41;
    cycles(1);
    stb2 = 1'b0;
    check("t3 level at first start", m_level, 2);
    check_frame("t3a", 4, 10, 16'h021A, 0);
    check("t3 level at second start", m_level, 1);
    check_frame("t3b", 4, 10, 16'h0214, 0);
    check("t3 level at last start", m_level, 0);
    check_frame("t3c", 4, 10, 16'h0282, 0);
    check("t3 busy after frames", m_busy, 0);

    // 4: depth 4, strobe held for 6 cycles while idle. The first word is
    // popped straight into the shifter, so five words are accepted and the
    // sixth (0x15) is dropped.
    check("t4 overflow before", m_overflow, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        check("t4 level full", m_level, 4);
        check("t4 ready low", m_ready, 0);
        check("t4 overflow not yet", m_overflow, 0);
      end
      d2 = 8'h10 + 8'(i);
      stb2 = 1'b1;
      cycles(1);
    end
    stb2 = 1'b0;
    check("t4 overflow set", m_overflow, 1);
    check("t4 level after drop", m_level, 4);
    check_frame("t4 f0", 4, 10, 16'h0220, 3);
    check_frame("t4 f1", 4, 10, 16'h0222, 0);
    check_frame("t4 f2", 4, 10, 16'h0224, 0);
    check_frame("t4 f3", 4, 10, 16'h0226, 0);
    check_frame("t4 f4", 4, 10, 16'h0228, 0);
    check("t4 busy after frames", m_busy, 0);
    cycles(12);
    check("t4 no extra frame", m_serial, 1);
    check("t4 overflow sticky", m_overflow, 1);
    check("t4 ready again", m_ready, 1);

    // 5: reset in the middle of data bit 3 of 0x55, with 0xAA queued
    d2 = 8'h55; stb2 = 1'b1;
    cycles(1);
    d2 = 8'hAA;
    cycles(1);
    stb2 = 1'b0;
    cycles(18);
    check("t5 serial in bit3", m_serial, 0);
    check("t5 level before reset", m_level, 1);
    rst2 = 1'b1;
    cycles(1);
    rst2 = 1'b0;
    check("t5 serial after reset", m_serial, 1);
    check("t5 level after reset", m_level, 0);
    check("t5 overflow after reset", m_overflow, 0);
    check("t5 busy after reset", m_busy, 0);
    check("t5 ready after reset", m_ready, 1);
    d2 = 8'h3C; stb2 = 1'b1;
    cycles(1);
    stb2 = 1'b0;
    check("t5 serial push+0", m_serial, 1);
    cycles(1);
    check("t5 serial push+1", m_serial, 1);
    cycles(1);
    check_frame("t5", 4, 10, 16'h0278, 0);
    check("t5 busy after frame", m_busy, 0);

    // 6: push on the cycle that ends the final stop bit while one word waits
    d2 = 8'h0F; stb2 = 1'b1;
    cycles(1);
    d2 = 8'hF0;
    cycles(1);
    stb2 = 1'b0;
    check("t6 level queued", m_level, 1);
    cycles(1);
    check_frame("t6a", 4, 9, 16'h001E, 0);
    check("t6 stop head", m_serial, 1);
    cycles(3);
    check("t6 stop tail", m_serial, 1);
    check("t6 level before push", m_level, 1);
    d2 = 8'h81; stb2 = 1'b1;
    cycles(1);
    stb2 = 1'b0;
    check("t6 level push+pop", m_level, 1);
    check("t6 no gap", m_serial, 0);
    check_frame("t6b", 4, 10, 16'h03E0, 0);
    check("t6 level at last start", m_level, 0);
    check_frame("t6c", 4, 10, 16'h0302, 0);
    check("t6 busy after frames", m_busy, 0);
    check("t6 idle line", m_serial, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
